gate2_tester: RTL and testbench
===============================

# gate2_tester

Self-checking stimulus/response engine for 2-input combinational gate blocks (nor2 and siblings). It drives the gate's `a`/`b` inputs through all four input combinations and samples the gate's `y` output after a programmable settle time. Each sample is compared against a parameterised truth table, and the block reports pass/fail per input vector. It sits on the opposite side of the gate's pins, as the driver of `a`/`b` and the consumer of `y`, for board bring-up and in-fabric self-test.

## Interface
Parameters:
- `TRUTH`, default 4'b0001: expected `y` indexed by `{a,b}`; bit0 = a0b0, bit3 = a1b1. The default is NOR.
- `SETTLE`, default 2: wait cycles between driving a vector and sampling `y`. Legal range 0..255.
- `ITER`, default 1: number of full 4-vector sweeps per run. Legal range 1..255.

Ports:
- `clk`  in  1  system clock. The single clock domain for the block.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request. Sampled only in IDLE.
- `a`  out  1  gate input A.
- `b`  out  1  gate input B.
- `y`  in  1  gate output. It must be combinationally derived from `a`/`b` in the `clk` domain, so no synchronizer is used.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at run completion.
- `pass`  out  1  high when the last run had zero mismatches. Held until the next start.
- `fail_vec`  out  4  sticky per-vector mismatch flags for the last run.
- `err_count`  out  8  total mismatches in the last run. Saturates at 255.

## Operation
- FSM states:
  - IDLE: `a`=`b`=0 and `busy`=0.
  - WAIT: a vector is being driven and the settle counter is running.
  - CHECK: a single-cycle state in which `y` is compared.
- Transitions:
  - IDLE→WAIT on `start`=1.
  - WAIT→CHECK when the settle counter is 0.
  - CHECK→WAIT if this is not the last vector of the last iteration.
  - CHECK→IDLE otherwise.
- Vector index `idx` (2-bit) increments 0→1→2→3→0, wrapping once per sweep. `{a,b}` = `idx` while in WAIT or CHECK. The iteration counter increments on the wrap.
- In CHECK, a mismatch (`y` != `TRUTH[idx]`) sets `fail_vec[idx]` and increments `err_count` (saturating).
- On accepting `start`, `fail_vec`, `err_count` and `pass` are cleared and `idx`=0.
- On completion, `pass` = (`err_count` == 0, including the final compare) and `done` pulses for exactly one cycle.
- `start` while `busy` is ignored, and `start` held high re-triggers only after returning to IDLE. The earliest re-accept is the cycle after `done`.
- Reset at any time, including mid-run:
  - Returns to IDLE.
  - `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `fail_vec`=0, `err_count`=0.
  - No `done` is produced for the aborted run.

## Timing
- Reset values of all outputs are 0.
- Edge E0 accepts `start`:
  - `busy`=1 and `{a,b}`=00 from E0.
  - The settle counter loads `SETTLE`, decrements once per edge, and is 0 at E`SETTLE`.
- Compare for vector k:
  - It occurs at edge E((k+1)·(`SETTLE`+1)) and uses `y` as it stands before that edge.
  - `{a,b}` changes to the next vector at that same edge.
- Each vector occupies `SETTLE`+1 cycles, so a run lasts 4·`ITER`·(`SETTLE`+1) cycles.
- At the final compare edge, `done`=1, `busy`=0, `{a,b}`=00, and `pass`/`fail_vec`/`err_count` are updated and valid in the same cycle.
- With `SETTLE`=0, each vector is compared one edge after it is driven.

## Structure
- Package `gate_test_pkg` holds:
  - The FSM state enum (IDLE, WAIT, CHECK).
  - Truth-table constants `TT_NOR2`=4'b0001, `TT_AND2`=4'b1000, `TT_OR2`=4'b1110, `TT_NAND2`=4'b0111, `TT_XOR2`=4'b0110.
- One natural sub-module: `settle_timer`, a loadable down-counter with a zero flag, sized `$clog2(SETTLE+1)` (minimum 1 bit). All other logic lives in `gate2_tester`.

## Test plan
- Real `nor2` attached, defaults, `start` pulse → `done` exactly 12 cycles after the start edge; `pass`=1, `fail_vec`=0000, `err_count`=0; observed `{a,b}` sequence 00,01,10,11 with 3 cycles each.
- `y` tied 0, `ITER`=3 → `fail_vec`=0001, `err_count`=3, `pass`=0, `done` at cycle 36.
- OR gate attached with `TRUTH`=`TT_NOR2` → `fail_vec`=1111, `err_count`=4, `pass`=0.
- `rst` asserted at cycle 5 of a run → next cycle all outputs 0; no `done` appears; a new `start` then completes normally with `pass`=1.
- `start` pulsed again at cycle 4 of a run → ignored, with `done` still at cycle 12. `start` held high continuously → back-to-back runs with `done` every 13 cycles.
- `SETTLE`=0, `nor2` attached → `done` 4 cycles after the start edge, `pass`=1.

Source files
------------

// File: rtl/gate2_tester_pkg.sv
// Shared types and truth-table constants for the 2-input gate tester.
// Also holds the width rule used to size the settle timer.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Expected y indexed by {a,b}: bit0 = a0b0 ... bit3 = a1b1
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

  function automatic int timer_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/gate2_tester_if.sv
// Pin bundle between the tester and the gate under test.
// The tester drives a/b and consumes y; the gate does the reverse.
interface gate2_tester_if;
  logic a;
  logic b;
  logic y;

  modport master (output a, output b, input y);
  modport slave  (input a, input b, output y);
endinterface

// File: rtl/gate2_tester_settle_timer.sv
// Loadable down-counter that stops at zero; used to hold each vector
// for the settle time before the compare cycle.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         expiring
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero     = (cnt_q == '0);
  // Reaches zero on the next edge
  assign expiring = (cnt_q == W'(1));

endmodule

// File: rtl/gate2_tester.sv
// Stimulus/response engine: sweeps {a,b} through 00..11, samples y after a
// settle time and compares against TRUTH, reporting per-vector results.
module gate2_tester
  import gate_test_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_NOR2,
  parameter int         SETTLE = 2,
  parameter int         ITER   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  gate2_tester_if.master        gate,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [3:0]            fail_vec,
  output logic [7:0]            err_count
);

  localparam int              TW        = timer_width(SETTLE);
  localparam logic [TW-1:0]   SETTLE_V  = TW'(SETTLE);
  localparam logic [7:0]      LAST_ITER = 8'(ITER - 1);
  // With no settle time a vector is compared in the very cycle it is driven
  localparam state_t          VEC_ENTRY = (SETTLE == 0) ? CHECK : WAIT;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  iter_q, iter_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  fail_q, fail_d;
  logic [7:0]  err_q, err_d;
  logic        tmr_load;
  logic        tmr_zero;
  logic        tmr_expiring;

  settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_V),
    .zero     (tmr_zero),
    .expiring (tmr_expiring)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    iter_d   = iter_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    fail_d   = fail_q;
    err_d    = err_q;
    tmr_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = VEC_ENTRY;
          idx_d    = 2'd0;
          iter_d   = 8'd0;
          pass_d   = 1'b0;
          fail_d   = 4'd0;
          err_d    = 8'd0;
          tmr_load = 1'b1;
        end
      end

      WAIT: begin
        if (tmr_expiring || tmr_zero) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (gate.y != TRUTH[idx_q]) begin
          fail_d[idx_q] = 1'b1;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          iter_d = iter_q + 8'd1;
        end
        if (idx_q == 2'd3 && iter_q == LAST_ITER) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          state_d  = VEC_ENTRY;
          tmr_load = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      iter_q  <= 8'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'd0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign gate.a    = busy & idx_q[1];
  assign gate.b    = busy & idx_q[0];
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate2_tester.sv
// Directed bench: four tester instances (nor2, stuck-at-0 x3 sweeps,
// OR gate against a NOR table, zero settle) exercised one scenario at a time.
module tb_gate2_tester;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start_n, start_z, start_o, start_s;
  logic busy_n, done_n, pass_n; logic [3:0] fail_n; logic [7:0] err_n;
  logic busy_z, done_z, pass_z; logic [3:0] fail_z; logic [7:0] err_z;
  logic busy_o, done_o, pass_o; logic [3:0] fail_o; logic [7:0] err_o;
  logic busy_s, done_s, pass_s; logic [3:0] fail_s; logic [7:0] err_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate2_tester_if if_n ();
  gate2_tester_if if_z ();
  gate2_tester_if if_o ();
  gate2_tester_if if_s ();

  assign if_n.y = ~(if_n.a | if_n.b);
  assign if_z.y = 1'b0;
  assign if_o.y = if_o.a | if_o.b;
  assign if_s.y = ~(if_s.a | if_s.b);

  wire [16:0] obs_n = {busy_n, done_n, pass_n, fail_n, err_n, if_n.a, if_n.b};
  wire [16:0] obs_z = {busy_z, done_z, pass_z, fail_z, err_z, if_z.a, if_z.b};
  wire [16:0] obs_o = {busy_o, done_o, pass_o, fail_o, err_o, if_o.a, if_o.b};
  wire [16:0] obs_s = {busy_s, done_s, pass_s, fail_s, err_s, if_s.a, if_s.b};

  gate2_tester u_nor (
    .clk(clk), .rst(rst), .start(start_n), .gate(if_n),
    .busy(busy_n), .done(done_n), .pass(pass_n), .fail_vec(fail_n), .err_count(err_n)
  );
  gate2_tester #(.ITER(3)) u_zero (
    .clk(clk), .rst(rst), .start(start_z), .gate(if_z),
    .busy(busy_z), .done(done_z), .pass(pass_z), .fail_vec(fail_z), .err_count(err_z)
  );
  gate2_tester #(.TRUTH(TT_NOR2)) u_or (
    .clk(clk), .rst(rst), .start(start_o), .gate(if_o),
    .busy(busy_o), .done(done_o), .pass(pass_o), .fail_vec(fail_o), .err_count(err_o)
  );
  gate2_tester #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_s), .gate(if_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_vec(fail_s), .err_count(err_s)
  );

  task automatic test_reset();
    rst = 1'b1;
    start_n = 1'b0; start_z = 1'b0; start_o = 1'b0; start_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (obs_n !== 17'd0) begin n_err++; $display("FAIL reset_nor: got %b want 0", obs_n); end
    n_vec++;
    if (obs_z !== 17'd0) begin n_err++; $display("FAIL reset_zero: got %b want 0", obs_z); end
    n_vec++;
    if (obs_o !== 17'd0) begin n_err++; $display("FAIL reset_or: got %b want 0", obs_o); end
    n_vec++;
    if (obs_s !== 17'd0) begin n_err++; $display("FAIL reset_s0: got %b want 0", obs_s); end
    rst = 1'b0;
    $display("[reset] all four testers checked idle");
  endtask

  task automatic test_nor_basic();
    logic [3:0] got, exp;
    @(negedge clk); start_n = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start_n = 1'b0;
      got = {busy_n, done_n, if_n.a, if_n.b};
      if (k < 12)       exp = {2'b10, 2'(k / 3)};
      else if (k == 12) exp = 4'b0100;
      else              exp = 4'b0000;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL nor_basic_c%0d: busy,done,ab=%b want %b", k, got, exp);
      end
      if (k == 12) begin
        n_vec++;
        if ({pass_n, fail_n, err_n} !== {1'b1, 4'b0000, 8'd0}) begin
          n_err++; $display("FAIL nor_basic_status: pass=%b fail_vec=%b err=%0d want 1 0000 0",
                            pass_n, fail_n, err_n);
        end
      end
      @(posedge clk);
    end
    $display("[nor_basic] pass=%b fail_vec=%b err_count=%0d", pass_n, fail_n, err_n);
  endtask

  task automatic test_stuck_zero();
    @(negedge clk); start_z = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start_z = 1'b0;
      n_vec++;
      if (done_z !== (k == 36)) begin
        n_err++; $display("FAIL stuck0_done_c%0d: done=%b want %b", k, done_z, (k == 36));
      end
      if (k == 36) begin
        n_vec++;
        if ({busy_z, pass_z, fail_z, err_z} !== {1'b0, 1'b0, 4'b0001, 8'd3}) begin
          n_err++; $display("FAIL stuck0_status: busy=%b pass=%b fail_vec=%b err=%0d want 0 0 0001 3",
                            busy_z, pass_z, fail_z, err_z);
        end
      end
      @(posedge clk);
    end
    $display("[stuck0] pass=%b fail_vec=%b err_count=%0d", pass_z, fail_z, err_z);
  endtask

  task automatic test_wrong_gate();
    @(negedge clk); start_o = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      start_o = 1'b0;
      if (k == 6) begin
        n_vec++;
        if ({pass_o, fail_o, err_o} !== {1'b0, 4'b0011, 8'd2}) begin
          n_err++; $display("FAIL or_midrun: pass=%b fail_vec=%b err=%0d want 0 0011 2",
                            pass_o, fail_o, err_o);
        end
      end
      if (k == 12) begin
        n_vec++;
        if ({done_o, pass_o, fail_o, err_o} !== {1'b1, 1'b0, 4'b1111, 8'd4}) begin
          n_err++; $display("FAIL or_status: done=%b pass=%b fail_vec=%b err=%0d want 1 0 1111 4",
                            done_o, pass_o, fail_o, err_o);
        end
      end
      @(posedge clk);
    end
    $display("[or_vs_nor] pass=%b fail_vec=%b err_count=%0d", pass_o, fail_o, err_o);
  endtask

  task automatic test_reset_midrun();
    int saw_done = 0;
    int done_at = -1;
    @(negedge clk); start_n = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start_n = 1'b0;
      if (k == 5) rst = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    n_vec++;
    if (obs_n !== 17'd0) begin n_err++; $display("FAIL midrun_reset: got %b want 0", obs_n); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (done_n) saw_done++;
    end
    n_vec++;
    if (saw_done !== 0) begin n_err++; $display("FAIL midrun_no_done: saw %0d done pulses want 0", saw_done); end
    start_n = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start_n = 1'b0;
      if (done_n && done_at < 0) begin
        done_at = k;
        n_vec++;
        if (pass_n !== 1'b1) begin n_err++; $display("FAIL rerun_pass: pass=%b want 1", pass_n); end
      end
      @(posedge clk);
    end
    n_vec++;
    if (done_at !== 12) begin n_err++; $display("FAIL rerun_done_cycle: done at %0d want 12", done_at); end
    $display("[reset_midrun] aborted run silent, rerun done at cycle %0d", done_at);
  endtask

  task automatic test_start_ignored();
    logic [3:0] got, exp;
    @(negedge clk); start_n = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start_n = (k == 4);
      got = {busy_n, done_n, if_n.a, if_n.b};
      if (k < 12)       exp = {2'b10, 2'(k / 3)};
      else if (k == 12) exp = 4'b0100;
      else              exp = 4'b0000;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL ignore_start_c%0d: busy,done,ab=%b want %b", k, got, exp);
      end
      @(posedge clk);
    end
    $display("[start_ignored] extra start at cycle 4 had no effect");
  endtask

  task automatic test_back_to_back();
    logic [1:0] got, exp;
    @(negedge clk); start_n = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if (k == 38) start_n = 1'b0;
      got = {busy_n, done_n};
      if (k == 12 || k == 25 || k == 38) exp = 2'b01;
      else if (k > 38)                   exp = 2'b00;
      else                               exp = 2'b10;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL back_to_back_c%0d: busy,done=%b want %b", k, got, exp);
      end
      @(posedge clk);
    end
    $display("[back_to_back] three runs with done every 13 cycles");
  endtask

  task automatic test_settle0();
    logic [3:0] got, exp;
    @(negedge clk); start_s = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      got = {busy_s, done_s, if_s.a, if_s.b};
      if (k < 4)       exp = {2'b10, 2'(k)};
      else if (k == 4) exp = 4'b0100;
      else             exp = 4'b0000;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL settle0_c%0d: busy,done,ab=%b want %b", k, got, exp);
      end
      if (k == 4) begin
        n_vec++;
        if ({pass_s, fail_s, err_s} !== {1'b1, 4'b0000, 8'd0}) begin
          n_err++; $display("FAIL settle0_status: pass=%b fail_vec=%b err=%0d want 1 0000 0",
                            pass_s, fail_s, err_s);
        end
      end
      @(posedge clk);
    end
    $display("[settle0] pass=%b err_count=%0d", pass_s, err_s);
  endtask

  initial begin
    test_reset();
    test_nor_basic();
    test_stuck_zero();
    test_wrong_gate();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    test_settle0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
